// File: rtl/vend_pkg.sv
// Shared definitions for the juice vending slice: scheduler state encodings,
// panel count and the coin codes also used by the coin-acceptor FSMs.
package vend_pkg;

  localparam int unsigned NUM_PANELS = 2;

  typedef logic [NUM_PANELS-1:0] panel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_10   = 2'd1;
  localparam logic [1:0] COIN_20   = 2'd2;
  localparam logic [1:0] COIN_50   = 2'd3;

endpackage

// File: rtl/vend_rr_arb.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes
// to the panel named by rr.
module vend_rr_arb
  import vend_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    grant = '0;
    idx   = 1'b0;
    unique case (req)
      2'b01: idx = 1'b0;
      2'b10: idx = 1'b1;
      2'b11: idx = rr;
      default: idx = 1'b0;
    endcase
    if (req != '0) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/vend_dispense_sched.sv
// Shared-dispenser scheduler: arbitrates panel requests, times the motor,
// waits for the cup drop, tracks stock and answers each panel with served/refund.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int unsigned DISP_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         vend_req,
  input  logic               refill,
  input  logic               drop_sense,
  output logic               motor_on,
  output logic [1:0]         served,
  output logic [1:0]         refund,
  output logic               busy,
  output logic [STOCK_W-1:0] stock,
  output logic               fault
);

  localparam int unsigned CNT_MAX = (DISP_CYCLES > TIMEOUT) ? DISP_CYCLES : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  panel_t             pending_q, pending_d;
  logic               rr_q, rr_d;
  logic               g_q, g_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dropped_q, dropped_d;
  logic               motor_on_q, motor_on_d;
  logic [1:0]         served_q, served_d;
  logic [1:0]         refund_q, refund_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               fault_q, fault_d;

  panel_t             pend_clr;
  panel_t             pend_kept;
  logic [1:0]         arb_grant;
  logic               arb_idx;

  vend_rr_arb u_arb (
    .req   (pending_q),
    .rr    (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    stock_d   = stock_q;
    fault_d   = fault_q;
    served_d  = '0;
    refund_d  = '0;
    pend_clr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (fault_q || stock_q == '0) begin
          refund_d = pending_q;
          pend_clr = pending_q;
        end else if (arb_grant != '0) begin
          g_d       = arb_idx;
          rr_d      = ~arb_idx;
          cnt_d     = '0;
          dropped_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (drop_sense) dropped_d = 1'b1;
        if (cnt_q == CNT_W'(DISP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (dropped_q || drop_sense) ? ST_DONE : ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (drop_sense) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d       = 1'b1;
          refund_d[g_q] = 1'b1;
          pend_clr[g_q] = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        served_d[g_q] = 1'b1;
        pend_clr[g_q] = 1'b1;
        stock_d       = stock_q - STOCK_W'(1);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A slot freed on this edge accepts a new request rather than refunding it,
    // so served/refund for one panel can never pulse together.
    pend_kept = pending_q & ~pend_clr;
    refund_d  = refund_d | (vend_req & pend_kept);
    pending_d = pend_kept | vend_req;

    if (refill) begin
      stock_d = STOCK_W'(STOCK_INIT);
      fault_d = 1'b0;
    end

    motor_on_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      rr_q       <= 1'b0;
      g_q        <= 1'b0;
      cnt_q      <= '0;
      dropped_q  <= 1'b0;
      motor_on_q <= 1'b0;
      served_q   <= '0;
      refund_q   <= '0;
      stock_q    <= STOCK_W'(STOCK_INIT);
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      dropped_q  <= dropped_d;
      motor_on_q <= motor_on_d;
      served_q   <= served_d;
      refund_q   <= refund_d;
      stock_q    <= stock_d;
      fault_q    <= fault_d;
    end
  end

  assign motor_on = motor_on_q;
  assign served   = served_q;
  assign refund   = refund_q;
  assign busy     = (state_q != ST_IDLE);
  assign stock    = stock_q;
  assign fault    = fault_q;

endmodule
